blimp_mem_responder: RTL
========================

Name: blimp_mem_responder

Overview:
- Synthesizable memory responder that sits on the far side of the processor's data-memory request/response interface.
- Services load (lw) and store (sw) requests issued by the core.
- Each response is returned after a fixed, configurable latency, in request order, with the opaque tag echoed.
- Replaces the behavioural test memory when a fixed response-latency model is needed; its responses feed the core's load-writeback path.

Parameters:
- p_opaq_bits, 8, width of opaque request tag echoed in response
- p_mem_words, 256, number of 32-bit words of backing storage (power of 2)
- p_base_addr, 32'h0, byte address of word 0
- p_resp_delay, 1, cycles from request accept to earliest resp_val (1..15)
- p_depth, 4, max outstanding requests held (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_val  in  1  request valid
- req_rdy  out  1  responder can accept request
- req_op  in  1  0 = load, 1 = store
- req_opaque  in  p_opaq_bits  request tag
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_strb  in  4  store byte enables
- resp_val  out  1  response valid
- resp_rdy  in  1  core accepts response
- resp_op  out  1  echoed op
- resp_opaque  out  p_opaq_bits  echoed tag
- resp_addr  out  32  echoed address
- resp_data  out  32  load data; 0 for stores and errors
- resp_err  out  1  misaligned or out-of-range access

Behaviour:
- Handshakes: a transfer occurs on a rising edge where val && rdy. req_rdy = (count < p_depth). No same-cycle bypass when full. resp_* are stable while resp_val && !resp_rdy.
- Reset: async on rst_n low. count = 0, FIFO pointers = 0, all timers = 0, req_rdy = 1, resp_val = 0, resp_data/opaque/addr/op/err = 0. Memory contents are not reset.
- Address check: idx = (req_addr - p_base_addr) >> 2. Error if req_addr[1:0] != 0 or idx >= p_mem_words.
- Accept, load: read mem[idx] at the accept edge; store data, op, opaque, addr and err in the FIFO entry.
- Accept, store: write the bytes of req_wdata enabled by req_strb into mem[idx] at the accept edge. Errored stores do not write.
- Ordering: loads accepted after a store see that store. A store never affects a load that was already accepted.
- Latency: each entry gets timer = p_resp_delay at accept. Every occupied entry's timer decrements by 1 per cycle until it reaches 0.
  - resp_val = (count > 0) && head timer == 0.
  - Minimum accept-to-resp_val latency is exactly p_resp_delay cycles.
  - Responses are strictly in request order.
- Throughput: one request and one response per cycle. With an accept and a dequeue on the same edge, count is unchanged.
- count is p_depth-bit wide (counts 0..p_depth). Pointers are log2(p_depth) bits and wrap modulo p_depth.
- Backpressure: when resp_rdy is low, entries still age. A younger entry's timer may hit 0 first, but it waits for the head.
- Reset mid-operation: all outstanding requests are dropped with no responses. Memory writes already committed persist.

Test Plan:
- Store then load: sw addr 0x10 data 0xDEADBEEF, strb 4'hF, tag 3; lw 0x10, tag 4 → store resp (op 1, tag 3, data 0, err 0) at accept+1. Load resp (tag 4, data 0xDEADBEEF) the following cycle.
- Byte strobes: mem[0x20] = 0x11223344; sw 0xAABBCCDD, strb 4'b0101; lw 0x20 → data 0x11BB33DD.
- Full/backpressure: p_depth 4, resp_rdy = 0, issue 5 loads → req_rdy drops after the 4th accept. Raise resp_rdy → responses come out in order tags 0..3, then the 5th is accepted.
- Latency: p_resp_delay = 3, a single lw accepted at cycle t → resp_val first high at t+3. Back-to-back lws → one response per cycle.
- Errors: lw 0x13 → err 1, data 0. lw at p_base_addr + 4*p_mem_words → err 1. sw 0x402 → err 1 and memory unchanged.
- Reset mid-flight: 3 loads outstanding, pulse rst_n low for 1 cycle → resp_val = 0 immediately and req_rdy = 1. No stale responses appear afterward. A prior store's data is still readable.

Source files
------------

// File: rtl/blimp_mem_if.sv
// Request/response bundle between the core's data-memory port and a memory responder.
// Handshake: each channel transfers on a rising clk edge where its val and rdy are both high.
interface blimp_mem_if #(
    parameter int unsigned p_opaq_bits = 8
);
    logic                   req_val;
    logic                   req_rdy;
    logic                   req_op;
    logic [p_opaq_bits-1:0] req_opaque;
    logic [31:0]            req_addr;
    logic [31:0]            req_wdata;
    logic [3:0]             req_strb;
    logic                   resp_val;
    logic                   resp_rdy;
    logic                   resp_op;
    logic [p_opaq_bits-1:0] resp_opaque;
    logic [31:0]            resp_addr;
    logic [31:0]            resp_data;
    logic                   resp_err;

    modport master (
        output req_val, req_op, req_opaque, req_addr, req_wdata, req_strb, resp_rdy,
        input  req_rdy, resp_val, resp_op, resp_opaque, resp_addr, resp_data, resp_err
    );

    modport slave (
        input  req_val, req_op, req_opaque, req_addr, req_wdata, req_strb, resp_rdy,
        output req_rdy, resp_val, resp_op, resp_opaque, resp_addr, resp_data, resp_err
    );
endinterface

// File: rtl/blimp_mem_responder.sv
// Data-memory responder: services lw/sw at the accept edge and returns in-order responses
// after a fixed latency through a small response FIFO with a per-entry countdown timer.
module blimp_mem_responder #(
    parameter int unsigned p_opaq_bits  = 8,
    parameter int unsigned p_mem_words  = 256,
    parameter logic [31:0] p_base_addr  = 32'h0,
    parameter int unsigned p_resp_delay = 1,
    parameter int unsigned p_depth      = 4
) (
    input logic        clk,
    input logic        rst_n,
    blimp_mem_if.slave mem
);
    localparam int unsigned AW = $clog2(p_mem_words);
    localparam int unsigned PW = $clog2(p_depth);
    localparam int unsigned CW = p_depth;
    localparam logic [3:0]  DELAY = 4'(p_resp_delay);

    typedef struct packed {
        logic                   op;
        logic [p_opaq_bits-1:0] opaque;
        logic [31:0]            addr;
        logic [31:0]            data;
        logic                   err;
    } entry_t;

    logic [31:0]   mem_q [p_mem_words];
    entry_t        fifo_q [p_depth];
    logic [3:0]    timer_q [p_depth];
    logic [3:0]    timer_d [p_depth];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   offset, word_idx;
    logic [AW-1:0] idx;
    logic          acc_err, req_rdy, resp_val, accept, dequeue;
    entry_t        new_entry, head_entry;

    always_comb begin
        offset   = mem.req_addr - p_base_addr;
        word_idx = offset >> 2;
        idx      = word_idx[AW-1:0];
        acc_err  = (mem.req_addr[1:0] != 2'b00) || (word_idx >= 32'(p_mem_words));
    end

    assign req_rdy    = (count_q < CW'(p_depth));
    assign head_entry = fifo_q[head_q];
    // Free slots always hold timer 0, so only the head's timer gates the response.
    assign resp_val   = (count_q != '0) && (timer_q[head_q] == 4'd0);
    assign accept     = mem.req_val && req_rdy;
    assign dequeue    = resp_val && mem.resp_rdy;

    always_comb begin
        new_entry.op     = mem.req_op;
        new_entry.opaque = mem.req_opaque;
        new_entry.addr   = mem.req_addr;
        new_entry.err    = acc_err;
        new_entry.data   = (!mem.req_op && !acc_err) ? mem_q[idx] : 32'h0;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < int'(p_depth); i++) begin
            timer_d[i] = (timer_q[i] != 4'd0) ? timer_q[i] - 4'd1 : 4'd0;
        end
        if (accept) begin
            timer_d[tail_q] = DELAY;
            tail_d          = tail_q + PW'(1);
        end
        if (dequeue) begin
            head_d = head_q + PW'(1);
        end
        case ({accept, dequeue})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(p_depth); i++) begin
                timer_q[i] <= 4'd0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < int'(p_depth); i++) begin
                timer_q[i] <= timer_d[i];
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_q[tail_q] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && mem.req_op && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (mem.req_strb[b]) begin
                    mem_q[idx][8*b +: 8] <= mem.req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        mem.req_rdy     = req_rdy;
        mem.resp_val    = resp_val;
        mem.resp_op     = resp_val ? head_entry.op     : 1'b0;
        mem.resp_opaque = resp_val ? head_entry.opaque : '0;
        mem.resp_addr   = resp_val ? head_entry.addr   : 32'h0;
        mem.resp_data   = resp_val ? head_entry.data   : 32'h0;
        mem.resp_err    = resp_val ? head_entry.err    : 1'b0;
    end
endmodule
